// File: rtl/hall_pkg.sv
// Hall sensor package: sector encoding, direction constants and the sector decode helpers.
// Latency: none (pure constants and functions).
// Backpressure: none.
package hall_pkg;

    // Illegal Hall codes: all sensors low or all sensors high.
    localparam logic [2:0] HALL_ILL_LO = 3'b000;
    localparam logic [2:0] HALL_ILL_HI = 3'b111;

    // Sector numbering for the 6-step commutation sequence.
    localparam logic [2:0] SEC_0 = 3'd0;
    localparam logic [2:0] SEC_1 = 3'd1;
    localparam logic [2:0] SEC_2 = 3'd2;
    localparam logic [2:0] SEC_3 = 3'd3;
    localparam logic [2:0] SEC_4 = 3'd4;
    localparam logic [2:0] SEC_5 = 3'd5;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef struct packed {
        logic       legal;
        logic [2:0] sector;
    } hall_dec_t;

    // Filtered {C,B,A} to sector; every 3-bit code is listed so no default is needed.
    function automatic hall_dec_t hall_decode(input logic [2:0] h);
        hall_dec_t d;
        d.legal  = 1'b1;
        d.sector = SEC_0;
        case (h)
            3'b001:      d.sector = SEC_0;
            3'b011:      d.sector = SEC_1;
            3'b010:      d.sector = SEC_2;
            3'b110:      d.sector = SEC_3;
            3'b100:      d.sector = SEC_4;
            3'b101:      d.sector = SEC_5;
            HALL_ILL_LO: d.legal  = 1'b0;
            HALL_ILL_HI: d.legal  = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] sector_next(input logic [2:0] s);
        return (s == SEC_5) ? SEC_0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] sector_prev(input logic [2:0] s);
        return (s == SEC_0) ? SEC_5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Hall input conditioner: 2-FF synchroniser per bit followed by a FILT_LEN-sample debounce.
// Latency: 2 + FILT_LEN cycles from a stable raw change to filt_o.
// Backpressure: none; samples every cycle.
//
// Ports:
//   CLK     - system clock, rising edge
//   RST     - asynchronous active-low reset
//   hall_i  - raw {C,B,A} Hall inputs, asynchronous to CLK
//   filt_o  - debounced Hall state
module hall_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] hall_i,
    output logic [2:0] filt_o
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       samp_q;          // previous synchronised sample
    logic [RUN_W-1:0] run_q, run_d;    // consecutive equal samples ending at sync2_q
    logic [2:0]       filt_q, filt_d;

    // Run length saturates at FILT_LEN so it never wraps on a long stable level.
    always_comb begin
        if (sync2_q == samp_q) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end else begin
            run_d = RUN_W'(1);
        end
        filt_d = (run_d == RUN_MAX) ? sync2_q : filt_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            samp_q  <= 3'b000;
            run_q   <= '0;
            filt_q  <= 3'b000;
        end else begin
            sync1_q <= hall_i;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            run_q   <= run_d;
            filt_q  <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/hall_speed_encoder.sv
// Hall front end: sector decode, direction, wrapping position and gated speed measurement.
// Latency: 3 + FILT_LEN cycles from a Hall change to sector/pos/dir/hall_err; speed strobes one cycle after the terminal gate cycle.
// Backpressure: none; speed_valid is a strobe with no handshake.
//
// Ports:
//   CLK, RST     - clock and asynchronous active-low reset
//   H            - raw Hall inputs {C,B,A}
//   en           - enable for the speed measurement only
//   gate_len     - gate window length in cycles (0 treated as 1)
//   sector, dir, pos       - decoded sector, last direction, position count
//   speed, speed_valid, speed_ovf - last window count, update strobe, saturation flag
//   hall_err     - one-cycle pulse on an illegal code or a skipped sector
module hall_speed_encoder
    import hall_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int GATE_W   = 16,
    parameter int FILT_LEN = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        H,
    input  logic              en,
    input  logic [GATE_W-1:0] gate_len,
    output logic [2:0]        sector,
    output logic              dir,
    output logic [CNT_W-1:0]  pos,
    output logic [CNT_W-1:0]  speed,
    output logic              speed_valid,
    output logic              speed_ovf,
    output logic              hall_err
);

    logic [2:0] filt;

    hall_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .CLK    (CLK),
        .RST    (RST),
        .hall_i (H),
        .filt_o (filt)
    );

    // ------------------------------------------------------------------
    // Decode / position tracking
    // ------------------------------------------------------------------
    logic [2:0]       sector_q, sector_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;
    logic             prev_vld_q, prev_vld_d;  // sector_q holds a real previous legal state
    logic [2:0]       last_q;                  // filtered code seen last cycle
    logic             step;                    // one valid single-sector transition this cycle
    hall_dec_t        dec;

    always_comb begin
        dec        = hall_decode(filt);
        sector_d   = sector_q;
        dir_d      = dir_q;
        pos_d      = pos_q;
        err_d      = 1'b0;
        prev_vld_d = prev_vld_q;
        step       = 1'b0;

        if (!dec.legal) begin
            // Only the entry into an illegal code is flagged, not every cycle it persists.
            err_d      = (filt != last_q);
            prev_vld_d = 1'b0;
        end else if (!prev_vld_q) begin
            // No trusted reference yet: adopt the sector without counting.
            sector_d   = dec.sector;
            prev_vld_d = 1'b1;
        end else if (dec.sector != sector_q) begin
            sector_d = dec.sector;
            if (dec.sector == sector_next(sector_q)) begin
                pos_d = pos_q + CNT_W'(1);
                dir_d = DIR_FWD;
                step  = 1'b1;
            end else if (dec.sector == sector_prev(sector_q)) begin
                pos_d = pos_q - CNT_W'(1);
                dir_d = DIR_REV;
                step  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Gate window / speed measurement
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [GATE_W-1:0] gate_last;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_sum;
    logic              ovf_q, ovf_d, ovf_sum;
    logic [CNT_W-1:0]  speed_q, speed_d;
    logic              speed_ovf_q, speed_ovf_d;
    logic              speed_vld_q, speed_vld_d;
    logic              edge_full;

    always_comb begin
        // A zero length behaves as one so every cycle closes a window.
        gate_last = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);

        // Count including this cycle's transition, saturating at all-ones.
        edge_full = &edge_cnt_q;
        edge_sum  = edge_full ? edge_cnt_q : edge_cnt_q + CNT_W'(step);
        ovf_sum   = ovf_q | (edge_full & step);

        gate_cnt_d  = gate_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        ovf_d       = ovf_q;
        speed_d     = speed_q;
        speed_ovf_d = speed_ovf_q;
        speed_vld_d = 1'b0;

        if (!en) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (gate_cnt_q >= gate_last) begin
            // >= rather than == so a shrunk gate_len closes the window at once.
            speed_d     = edge_sum;
            speed_ovf_d = ovf_sum;
            speed_vld_d = 1'b1;
            gate_cnt_d  = '0;
            edge_cnt_d  = '0;
            ovf_d       = 1'b0;
        end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            edge_cnt_d = edge_sum;
            ovf_d      = ovf_sum;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sector_q    <= SEC_0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            err_q       <= 1'b0;
            prev_vld_q  <= 1'b0;
            last_q      <= HALL_ILL_LO;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            speed_q     <= '0;
            speed_ovf_q <= 1'b0;
            speed_vld_q <= 1'b0;
        end else begin
            sector_q    <= sector_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            err_q       <= err_d;
            prev_vld_q  <= prev_vld_d;
            last_q      <= filt;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            ovf_q       <= ovf_d;
            speed_q     <= speed_d;
            speed_ovf_q <= speed_ovf_d;
            speed_vld_q <= speed_vld_d;
        end
    end

    assign sector      = sector_q;
    assign dir         = dir_q;
    assign pos         = pos_q;
    assign hall_err    = err_q;
    assign speed       = speed_q;
    assign speed_ovf   = speed_ovf_q;
    assign speed_valid = speed_vld_q;

endmodule

// File: tb/tb_hall_speed_encoder.sv
module tb_hall_speed_encoder;

    localparam int FL = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  H;
    logic        en;
    logic [15:0] gate_len;

    logic [2:0] sector8, sector4;
    logic       dir8, dir4;
    logic [7:0] pos8, speed8;
    logic [3:0] pos4, speed4;
    logic       valid8, valid4, ovf8, ovf4, err8, err4;

    always #5 CLK = ~CLK;

    hall_speed_encoder #(.CNT_W(8), .GATE_W(16), .FILT_LEN(FL)) dut8 (
        .CLK(CLK), .RST(RST), .H(H), .en(en), .gate_len(gate_len),
        .sector(sector8), .dir(dir8), .pos(pos8), .speed(speed8),
        .speed_valid(valid8), .speed_ovf(ovf8), .hall_err(err8)
    );

    hall_speed_encoder #(.CNT_W(4), .GATE_W(16), .FILT_LEN(FL)) dut4 (
        .CLK(CLK), .RST(RST), .H(H), .en(en), .gate_len(gate_len),
        .sector(sector4), .dir(dir4), .pos(pos4), .speed(speed4),
        .speed_valid(valid4), .speed_ovf(ovf4), .hall_err(err4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int err_seen   = 0;
    int valid_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Forward order of Hall codes; index equals sector.
    logic [2:0] hseq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    function automatic int sec_of(input logic [2:0] h);
        for (int i = 0; i < 6; i++) if (hseq[i] == h) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model + per-cycle compare
    // hist[k] = raw H sampled k edges ago; the decoder sees a code once the
    // FL samples taken 2..FL+1 edges ago all agree.
    // ------------------------------------------------------------------
    logic [2:0] hist [0:FL+1];
    logic [2:0] mfilt, mlast;
    int  msec, mpos, mcyc, mtrans, mspeed, m_s, m_gl;
    bit  mprev, mdir, merr, mvalid, m_step, m_same;

    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            for (int i = 0; i <= FL + 1; i++) hist[i] = 3'b000;
            mfilt = 3'b000; mlast = 3'b000;
            msec = 0; mpos = 0; mprev = 0; mdir = 0; merr = 0;
            mcyc = 0; mtrans = 0; mspeed = 0; mvalid = 0;
        end else begin
            m_step = 0;
            merr   = 0;
            m_s    = sec_of(mfilt);
            if (m_s < 0) begin
                merr  = (mfilt != mlast);
                mprev = 0;
            end else if (!mprev) begin
                msec  = m_s;
                mprev = 1;
            end else if (m_s != msec) begin
                case ((m_s - msec + 6) % 6)
                    1:       begin mpos = mpos + 1; mdir = 1; m_step = 1; end
                    5:       begin mpos = mpos - 1; mdir = 0; m_step = 1; end
                    default: merr = 1;
                endcase
                msec = m_s;
            end
            mlast = mfilt;

            mvalid = 0;
            if (!en) begin
                mcyc = 0; mtrans = 0;
            end else begin
                m_gl   = (gate_len == 16'd0) ? 1 : int'(gate_len);
                mcyc   = mcyc + 1;
                mtrans = mtrans + int'(m_step);
                if (mcyc >= m_gl) begin
                    mspeed = mtrans; mvalid = 1; mcyc = 0; mtrans = 0;
                end
            end

            for (int i = FL + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = H;
            m_same = 1;
            for (int i = 3; i <= FL + 1; i++) if (hist[i] != hist[2]) m_same = 0;
            if (m_same) mfilt = hist[2];
        end
        #1;
        check("sector8", 32'(sector8), 32'(msec));
        check("sector4", 32'(sector4), 32'(msec));
        check("pos8",    32'(pos8),    32'(mpos & 255));
        check("pos4",    32'(pos4),    32'(mpos & 15));
        check("dir8",    32'(dir8),    32'(mdir));
        check("dir4",    32'(dir4),    32'(mdir));
        check("err8",    32'(err8),    32'(merr));
        check("err4",    32'(err4),    32'(merr));
        check("valid8",  32'(valid8),  32'(mvalid));
        check("valid4",  32'(valid4),  32'(mvalid));
        check("speed8",  32'(speed8),  32'((mspeed > 255) ? 255 : mspeed));
        check("ovf8",    32'(ovf8),    32'(mspeed > 255));
        check("speed4",  32'(speed4),  32'((mspeed > 15) ? 15 : mspeed));
        check("ovf4",    32'(ovf4),    32'(mspeed > 15));
        if (err8 === 1'b1)   err_seen++;
        if (valid8 === 1'b1) valid_seen++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus helpers (all drives happen on the falling edge)
    // ------------------------------------------------------------------
    int cur;

    task automatic hold(input logic [2:0] h, input int n);
        @(negedge CLK);
        H = h;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic step_fwd(input int n);
        cur = (cur + 1) % 6;
        hold(hseq[cur], n);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Returns after the rising edge whose registered result raises speed_valid.
    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
        end while (valid8 !== 1'b1 && n < max);
        if (valid8 !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL strobe_timeout: got none expected strobe within %0d cycles", max);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    int n, t0, e0, v0;

    initial begin
        RST = 1'b1; H = 3'b000; en = 1'b0; gate_len = 16'd0;
        #2 RST = 1'b0;
        #1;
        check("rst_sector", 32'(sector8), 32'd0);
        check("rst_pos",    32'(pos8),    32'd0);
        check("rst_dir",    32'(dir8),    32'd0);
        check("rst_speed",  32'(speed8),  32'd0);
        check("rst_valid",  32'(valid8),  32'd0);
        check("rst_ovf",    32'(ovf8),    32'd0);
        check("rst_err",    32'(err8),    32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // Forward full revolution: 001 ... 101, 001
        e0 = err_seen;
        cur = 0;
        hold(hseq[0], 20);
        repeat (6) step_fwd(20);
        check("fwd_sector", 32'(sector8), 32'd0);
        check("fwd_pos",    32'(pos8),    32'd6);
        check("fwd_pos4",   32'(pos4),    32'd6);
        check("fwd_dir",    32'(dir8),    32'd1);
        check("fwd_noerr",  32'(err_seen - e0), 32'd0);

        // Reverse from 001: 101, 100
        do_reset();
        hold(3'b001, 20);
        hold(3'b101, 20);
        hold(3'b100, 20);
        check("rev_pos",    32'(pos8),    32'hFE);
        check("rev_pos4",   32'(pos4),    32'hE);
        check("rev_dir",    32'(dir8),    32'd0);
        check("rev_sector", 32'(sector8), 32'd4);

        // 100-cycle window: 6 early transitions plus one counted on the terminal edge
        cur = 4;
        gate_len = 16'd100;
        en = 1'b1;
        wait_strobe(300, n);
        t0 = cyc;
        for (int k = 0; k < 6; k++) step_fwd(12);
        repeat (23) @(negedge CLK);
        cur = (cur + 1) % 6;
        H = hseq[cur];
        wait_strobe(50, n);
        check("win_period", 32'(cyc - t0), 32'd100);
        check("win_speed",  32'(speed8),   32'd7);
        check("win_ovf",    32'(ovf8),     32'd0);
        t0 = cyc;
        wait_strobe(150, n);
        check("idle_period", 32'(cyc - t0), 32'd100);
        check("idle_speed",  32'(speed8),   32'd0);

        // Saturation at CNT_W=4: 20 transitions, then 3
        gate_len = 16'd150;
        wait_strobe(200, n);
        for (int k = 0; k < 20; k++) step_fwd(5);
        wait_strobe(200, n);
        check("sat_speed8", 32'(speed8), 32'd20);
        check("sat_ovf8",   32'(ovf8),   32'd0);
        check("sat_speed4", 32'(speed4), 32'd15);
        check("sat_ovf4",   32'(ovf4),   32'd1);
        for (int k = 0; k < 3; k++) step_fwd(10);
        wait_strobe(200, n);
        check("post_speed4", 32'(speed4), 32'd3);
        check("post_ovf4",   32'(ovf4),   32'd0);

        // Shrinking gate_len mid-window closes it on the next edge
        repeat (50) @(negedge CLK);
        gate_len = 16'd10;
        wait_strobe(20, n);
        check("shrink_latency", 32'(n), 32'd1);

        // gate_len = 0: a strobe every cycle
        @(negedge CLK);
        gate_len = 16'd0;
        v0 = valid_seen;
        repeat (10) @(negedge CLK);
        check("gate0_strobes", 32'(valid_seen - v0), 32'd10);

        // en low: no strobes, position still tracks
        en = 1'b0;
        v0 = valid_seen;
        repeat (3) step_fwd(10);
        check("en0_strobes", 32'(valid_seen - v0), 32'd0);

        // Illegal code, recovery and skipped sector
        do_reset();
        hold(3'b011, 20);
        e0 = err_seen;
        hold(3'b111, 20);
        check("ill_err",    32'(err_seen - e0), 32'd1);
        check("ill_pos",    32'(pos8),    32'd0);
        check("ill_sector", 32'(sector8), 32'd1);
        hold(3'b011, 20);
        check("rec_err",    32'(err_seen - e0), 32'd1);
        check("rec_pos",    32'(pos8),    32'd0);
        hold(3'b110, 20);
        check("jump_err",    32'(err_seen - e0), 32'd2);
        check("jump_sector", 32'(sector8), 32'd3);
        check("jump_pos",    32'(pos8),    32'd0);

        // Two-sample glitch is filtered out
        e0 = err_seen;
        hold(3'b100, 2);
        hold(3'b110, 20);
        check("glitch_sector", 32'(sector8), 32'd3);
        check("glitch_pos",    32'(pos8),    32'd0);
        check("glitch_err",    32'(err_seen - e0), 32'd0);

        // Reset in the middle of a window
        gate_len = 16'd40;
        en = 1'b1;
        wait_strobe(100, n);
        hold(3'b100, 12);
        hold(3'b101, 12);
        wait_strobe(100, n);
        check("pre_rst_pos",   32'(pos8),   32'd2);
        check("pre_rst_speed", 32'(speed8), 32'd2);
        repeat (15) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("mid_rst_sector", 32'(sector8), 32'd0);
        check("mid_rst_pos",    32'(pos8),    32'd0);
        check("mid_rst_speed",  32'(speed8),  32'd0);
        check("mid_rst_dir",    32'(dir8),    32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        // Full-length first window: strobe is raised by the 40th rising edge after release.
        wait_strobe(100, n);
        check("rst_first_window", 32'(n), 32'd40);

        repeat (5) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
